// File: rtl/mdu_e.sv
// Multiply/divide unit for the E stage: fixed-latency mult/div with HI/LO commit and mfhi/mflo read.
// Optional madd/maddu support is enabled by defining MDU_MADD_EN.
module mdu_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MDValid,
  input  logic [2:0]  MDOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        ReadSel,
  output logic [31:0] MDOut,
  output logic        Busy
);

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b, quo_u, rem_u, quo_s, rem_s, quo_uu, rem_uu;
  logic        div_zero;

  assign prod_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
  assign prod_u = {32'b0, SrcA} * {32'b0, SrcB};

  // Signed divide on magnitudes avoids the INT_MIN / -1 trap; negating 0x80000000 wraps to itself.
  assign a_neg    = SrcA[31];
  assign b_neg    = SrcB[31];
  assign mag_a    = a_neg ? (32'd0 - SrcA) : SrcA;
  assign mag_b    = b_neg ? (32'd0 - SrcB) : SrcB;
  assign div_zero = (SrcB == 32'd0);
  assign quo_u    = div_zero ? 32'd0 : mag_a / mag_b;
  assign rem_u    = div_zero ? 32'd0 : mag_a % mag_b;
  assign quo_s    = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
  assign rem_s    = a_neg ? (32'd0 - rem_u) : rem_u;
  assign quo_uu   = div_zero ? 32'd0 : SrcA / SrcB;
  assign rem_uu   = div_zero ? 32'd0 : SrcA % SrcB;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (MDValid) begin
      case (MDOp)
        3'd0: begin
          {pend_hi_d, pend_lo_d} = prod_s;
          cnt_d                  = MultCnt;
        end
        3'd1: begin
          {pend_hi_d, pend_lo_d} = prod_u;
          cnt_d                  = MultCnt;
        end
        3'd2: begin
          // Divide by zero commits the current HI/LO back, leaving them unchanged.
          pend_hi_d = div_zero ? hi_q : rem_s;
          pend_lo_d = div_zero ? lo_q : quo_s;
          cnt_d     = DivCnt;
        end
        3'd3: begin
          pend_hi_d = div_zero ? hi_q : rem_uu;
          pend_lo_d = div_zero ? lo_q : quo_uu;
          cnt_d     = DivCnt;
        end
        3'd4: hi_d = SrcA;
        3'd5: lo_d = SrcA;
`ifdef MDU_MADD_EN
        3'd6: begin
          {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
          cnt_d                  = MultCnt;
        end
        3'd7: begin
          {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
          cnt_d                  = MultCnt;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      cnt_q     <= 4'd0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Busy  = (cnt_q != 4'd0);
  assign MDOut = ReadSel ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu_e.sv
// Scoreboard bench for mdu_e: stimulus queues expected HI/LO, a monitor checks on Busy fall or snapshots.
module tb_mdu_e;

  logic        CLK = 1'b0;
  logic        Reset, MDValid, ReadSel;
  logic [2:0]  MDOp;
  logic [31:0] SrcA, SrcB, MDOut;
  logic        Busy;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .CLK(CLK), .Reset(Reset), .MDValid(MDValid), .MDOp(MDOp), .SrcA(SrcA), .SrcB(SrcB),
    .ReadSel(ReadSel), .MDOut(MDOut), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct { string name; logic [31:0] hi; logic [31:0] lo; int len; } fall_t;
  typedef struct { string name; logic [31:0] hi; logic [31:0] lo; logic busy; } snap_t;

  fall_t fall_q[$];
  snap_t snap_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int snap_req = 0;
  int snap_done = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic read_out(output logic [31:0] h, output logic [31:0] l);
    ReadSel = 1'b0;
    #1 h = MDOut;
    ReadSel = 1'b1;
    #1 l = MDOut;
    ReadSel = 1'b0;
  endtask

  // Monitor: owns ReadSel; checks a commit whenever Busy falls, and snapshots on request.
  initial begin
    int run;
    fall_t f;
    snap_t s;
    logic [31:0] h, l;
    run = 0;
    ReadSel = 1'b0;
    forever begin
      @(negedge CLK);
      if (Busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (fall_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_busy: busy ran %0d cycles with nothing expected", run);
        end else begin
          f = fall_q.pop_front();
          read_out(h, l);
          check32({f.name, "_busy_len"}, 32'(run), 32'(f.len));
          check32({f.name, "_hi"}, h, f.hi);
          check32({f.name, "_lo"}, l, f.lo);
        end
        run = 0;
      end
      if (snap_req != snap_done) begin
        s = snap_q.pop_front();
        check32({s.name, "_busy"}, {31'd0, Busy}, {31'd0, s.busy});
        read_out(h, l);
        check32({s.name, "_hi"}, h, s.hi);
        check32({s.name, "_lo"}, l, s.lo);
        snap_done++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    MDValid = 1'b1;
    MDOp    = op;
    SrcA    = a;
    SrcB    = b;
    @(posedge CLK);
    #1 MDValid = 1'b0;
  endtask

  task automatic expect_op(input string name, input logic [31:0] hi, input logic [31:0] lo,
                           input int len);
    fall_t f;
    f.name = name; f.hi = hi; f.lo = lo; f.len = len;
    fall_q.push_back(f);
  endtask

  task automatic snap(input string name, input logic busy, input logic [31:0] hi,
                      input logic [31:0] lo);
    snap_t s;
    s.name = name; s.hi = hi; s.lo = lo; s.busy = busy;
    snap_q.push_back(s);
    snap_req++;
    @(negedge CLK);
    #4;
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    #4;
    if (!idle) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_idle: Busy still 1 after 40 cycles, expected 0", name);
    end
  endtask

  initial begin
    Reset = 1'b1; MDValid = 1'b0; MDOp = 3'd0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;
    snap("reset", 1'b0, 32'h0, 32'h0);

    expect_op("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle("mult");

    expect_op("multu", 32'h00000002, 32'hFFFFFFFA, 5);
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle("multu");

    expect_op("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_neg");

    expect_op("divu", 32'd1, 32'd3, 10);
    issue(3'd3, 32'd7, 32'd2);
    wait_idle("divu");

    expect_op("div_ovf", 32'h0, 32'h80000000, 10);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");

    issue(3'd4, 32'h12345678, 32'd0);
    issue(3'd5, 32'h9ABCDEF0, 32'd0);
    snap("mthi_mtlo", 1'b0, 32'h12345678, 32'h9ABCDEF0);

    expect_op("divu_zero", 32'h12345678, 32'h9ABCDEF0, 10);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle("divu_zero");

    // mtlo during Busy must be dropped; pending product must stay hidden.
    expect_op("mult_ign", 32'h0, 32'd12, 5);
    issue(3'd0, 32'd3, 32'd4);
    snap("pending_hidden", 1'b1, 32'h12345678, 32'h9ABCDEF0);
    issue(3'd5, 32'h0000DEAD, 32'd0);
    wait_idle("mult_ign");

    // Reset in the third Busy cycle: Busy falls after 3 cycles with HI=LO=0.
    expect_op("reset_mid", 32'h0, 32'h0, 3);
    issue(3'd2, 32'd100, 32'd7);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK);
    #1 Reset = 1'b0;
    wait_idle("reset_mid");
    repeat (12) @(negedge CLK);
    #4;
    snap("no_late_commit", 1'b0, 32'h0, 32'h0);

    issue(3'd5, 32'h000000AA, 32'd0);
    @(negedge CLK);
    Reset = 1'b1; MDValid = 1'b1; MDOp = 3'd4; SrcA = 32'h55;
    @(posedge CLK);
    #1 Reset = 1'b0; MDValid = 1'b0;
    snap("reset_wins", 1'b0, 32'h0, 32'h0);

    issue(3'd4, 32'd1, 32'd0);
    issue(3'd5, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    expect_op("madd", 32'd2, 32'd5, 5);
    issue(3'd6, 32'd2, 32'd3);
    wait_idle("madd");
`else
    issue(3'd6, 32'd2, 32'd3);
    repeat (8) @(negedge CLK);
    #4;
    snap("madd_off", 1'b0, 32'd1, 32'hFFFFFFFF);
`endif

    repeat (2) @(negedge CLK);
    check32("fall_q_drained", 32'(fall_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_e.md
# mdu_e

Multiply/divide unit for the E pipeline stage. It executes mult/multu/div/divu with fixed multi-cycle latency and holds the architectural HI/LO registers. It serves mfhi/mflo by driving a combinational read value into the E-stage result path, which becomes ALUOutput_M for the M stage. It also exports Busy so the hazard unit can stall D while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu/madd/maddu.
- DIV_CYCLES, 10, Busy duration for div/divu.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high; sampled on posedge CLK.
- MDValid  in  1  one-cycle strobe: MDOp is a real instruction this cycle.
- MDOp  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
- SrcA  in  32  forwarded rs value.
- SrcB  in  32  forwarded rt value.
- ReadSel  in  1  0 selects HI, 1 selects LO.
- MDOut  out  32  combinational: ReadSel ? LO : HI (committed values only).
- Busy  out  1  registered; high while an arithmetic op is in flight.

## Operation
- State:
  - HI, LO (32 each).
  - PendHI, PendLO (32 each).
  - Cnt (4 bits).
  - Busy = (Cnt != 0).
- Accept rule: an op is accepted only when MDValid=1 and Busy=0. MDValid with Busy=1 is ignored entirely; the hazard unit guarantees this never happens for real instructions.
- Arithmetic ops (0–3, 6–7), on accept:
  - Compute the result from SrcA/SrcB into PendHI/PendLO.
  - Load Cnt with MULT_CYCLES or DIV_CYCLES.
- Results per op:
  - mult: {PendHI,PendLO} = signed 64-bit SrcA*SrcB.
  - multu: same, unsigned.
  - div: PendLO = signed quotient, PendHI = signed remainder. The remainder takes the sign of the dividend (truncating division).
  - divu: same, unsigned.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (SrcB=0, div or divu): Pend* loaded with the current HI/LO, so HI/LO are unchanged at commit. Busy still runs DIV_CYCLES.
- mthi/mtlo on accept: write HI or LO at that edge. Busy is unaffected; visible on MDOut next cycle.
- Countdown: each cycle with Cnt>0, Cnt decrements. On the edge where Cnt goes 1→0, HI<=PendHI and LO<=PendLO.
- MDOut never shows pending values. A stalled mfhi/mflo reads only after Busy falls.

## Timing
- Reset edge:
  - HI, LO, PendHI, PendLO, Cnt all go to 0.
  - Busy=0 and MDOut=0 in the following cycle.
  - Reset mid-operation discards the pending result; no commit occurs.
  - Reset wins over a simultaneous MDValid.
- Accept at edge t0: Busy=1 for cycles t0+1 … t0+N, where N is MULT_CYCLES or DIV_CYCLES.
  - The commit edge is t0+N.
  - Busy=0 and the new HI/LO appear on MDOut in cycle t0+N+1 (after that edge).
- Back-to-back: a new op may be accepted at the commit edge t0+N only if Busy was already 0 in that cycle. It cannot be, so the earliest next accept is t0+N+1.
- Cnt width covers values up to 15; parameters above 15 are illegal.

## Configuration
- Macro MDU_MADD_EN.
  - Defined: MDOp 6/7 accepted. Pend = {HI,LO} + signed (madd) or unsigned (maddu) 64-bit SrcA*SrcB, computed at accept using the committed HI/LO, modulo 2^64. Latency is MULT_CYCLES.
  - Undefined: MDOp 6/7 ignored as no-ops. No Busy, no HI/LO change.

## Test plan
- mult A=0xFFFFFFFE, B=3 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x12345678, mtlo 0x9ABCDEF0 in consecutive cycles, then divu A=5, B=0 → after 10 Busy cycles HI/LO still 0x12345678/0x9ABCDEF0. MDOut with ReadSel toggled reads each.
- Start div, assert Reset in the 3rd Busy cycle → next cycle Busy=0, HI=LO=0, and no commit occurs later.
- mult issued and MDValid pulsed with mtlo 0xDEAD during Busy → mtlo ignored; HI/LO equal the mult result after commit.
- With MDU_MADD_EN defined: mthi 1, mtlo 0xFFFFFFFF, madd A=2, B=3 → HI=2, LO=5. Without the macro: same stimulus leaves HI=1, LO=0xFFFFFFFF, and Busy never rises.
